// File: rtl/uk101_video_gen_if.sv
// uk101_video_gen_if: display RAM / character ROM bus and video outputs of the UK101 video generator
interface uk101_video_gen_if;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_data;
  logic [10:0] crom_addr;
  logic [7:0]  crom_data;
  logic        r;
  logic        g;
  logic        b;
  logic        hsync;
  logic        vsync;
  logic        hblank;
  logic        vblank;
  logic        de;
  modport master (
    output vram_addr, crom_addr, r, g, b, hsync, vsync, hblank, vblank, de,
    input  vram_data, crom_data
  );
  modport slave (
    input  vram_addr, crom_addr, r, g, b, hsync, vsync, hblank, vblank, de,
    output vram_data, crom_data
  );
endinterface

// File: rtl/uk101_video_gen.sv
// uk101_video_gen: 48x16 character-mapped video generator with 3-tick aligned pixel and sync outputs
module uk101_video_gen (
  input logic        clk,
  input logic        n_reset,
  input logic        ce_pix,
  input logic [1:0]  colours,
  uk101_video_gen_if.master bus
);
  localparam logic [8:0] H_ACTIVE = 9'd384;
  localparam logic [8:0] H_FP     = 9'd16;
  localparam logic [8:0] H_SYNC   = 9'd40;
  localparam logic [8:0] H_TOTAL  = 9'd493;
  localparam logic [8:0] V_ACTIVE = 9'd256;
  localparam logic [8:0] V_FP     = 9'd16;
  localparam logic [8:0] V_SYNC   = 9'd4;
  localparam logic [8:0] V_TOTAL  = 9'd312;
  logic [8:0]      h;
  logic [8:0]      v;
  logic [7:0]      shifter;
  logic [2:0][3:0] dly;
  logic [3:0]      timing;
  logic            active;
  logic            de;
  // blank/sync flags for the current beam position, ordered {hblank, vblank, hsync, vsync}
  always_comb begin
    active = h < H_ACTIVE && v < V_ACTIVE;
    timing = {h >= H_ACTIVE, v >= V_ACTIVE,
              !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC),
              !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC)};
  end
  // beam position counters
  always_ff @(posedge clk)
    if (!n_reset) begin
      h <= '0;
      v <= '0;
    end else if (ce_pix) begin
      h <= h == H_TOTAL - 9'd1 ? 9'd0 : h + 9'd1;
      if (h == H_TOTAL - 9'd1) v <= v == V_TOTAL - 9'd1 ? 9'd0 : v + 9'd1;
    end
  // character fetch: RAM address at px0, glyph address at px1, shifter load at px2
  always_ff @(posedge clk)
    if (!n_reset) begin
      bus.vram_addr <= '0;
      bus.crom_addr <= '0;
      shifter       <= '0;
    end else if (ce_pix) begin
      if (active && h[2:0] == 3'd0) bus.vram_addr <= {v[7:4], h[8:3]};
      if (active && h[2:0] == 3'd1) bus.crom_addr <= {bus.vram_data, v[3:1]};
      shifter <= active && h[2:0] == 3'd2 ? bus.crom_data : {shifter[6:0], 1'b0};
    end
  // delay line keeping syncs and blanks aligned with the serialised pixel
  always_ff @(posedge clk)
    if (!n_reset) dly <= '1;
    else if (ce_pix) dly <= {dly[1:0], timing};
  // output sync/blank and colour mapping, black whenever blanked
  always_comb begin
    de         = !(dly[2][3] | dly[2][2]);
    bus.hblank = dly[2][3];
    bus.vblank = dly[2][2];
    bus.hsync  = dly[2][1];
    bus.vsync  = dly[2][0];
    bus.de     = de;
    bus.r      = de & shifter[7] & (colours != 2'b10);
    bus.g      = de & shifter[7];
    bus.b      = de & (shifter[7] ? !colours[1] : colours == 2'b00);
  end
endmodule

// File: tb/tb_uk101_video_gen.sv
// tb_uk101_video_gen: scoreboard plus glyph vector table for the UK101 video generator
module tb_uk101_video_gen;
  typedef struct packed {logic hs; logic vs; logic hb; logic vb; logic pix;} exp_t;
  typedef struct {logic [1:0] col; logic [7:0] ch; logic [7:0] gl; logic [10:0] ca; logic [23:0] rgb;} vec_t;
  localparam exp_t RST = 5'b11110;
  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       ce_pix = 1'b0;
  logic [1:0] colours = 2'b01;
  logic [7:0] vram [1024];
  logic [7:0] crom [2048];
  exp_t       q[$];
  exp_t       cur;
  vec_t       vecs [5];
  int         mh, mv, t;
  int         checks = 0;
  int         errors = 0;
  uk101_video_gen_if bus();
  uk101_video_gen dut (.clk(clk), .n_reset(n_reset), .ce_pix(ce_pix), .colours(colours), .bus(bus));
  always #5 clk = ~clk;
  // synchronous RAM/ROM models with one clock of read latency
  always @(posedge clk) begin
    bus.vram_data <= vram[bus.vram_addr];
    bus.crom_data <= crom[bus.crom_addr];
  end
  function automatic logic [2:0] rgb_of(input logic p, input logic [1:0] c);
    case ({p, c})
      3'b100, 3'b101: return 3'b111;
      3'b110:         return 3'b010;
      3'b111:         return 3'b110;
      3'b000:         return 3'b001;
      default:        return 3'b000;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask
  task automatic cyc(input logic ce, input logic rn);
    exp_t e;
    logic [9:0] a;
    logic [10:0] ca;
    logic cva, cca, blank;
    ce_pix = ce;
    n_reset = rn;
    @(posedge clk);
    #1;
    a = '0; ca = '0; cva = 1'b0; cca = 1'b0;
    if (!rn) begin
      mh = 0; mv = 0;
      q.delete();
      q.push_back(RST);
      q.push_back(RST);
      cur = RST; cva = 1'b1; cca = 1'b1;
    end else if (ce) begin
      e.hb = mh >= 384;
      e.vb = mv >= 256;
      e.hs = !(mh >= 400 && mh < 440);
      e.vs = !(mv >= 272 && mv < 276);
      a = 10'((mv / 16) * 64 + mh / 8);
      ca = {vram[a], 3'((mv / 2) % 8)};
      e.pix = (e.hb || e.vb) ? 1'b0 : crom[ca][7 - (mh % 8)];
      cva = !(e.hb || e.vb) && mh % 8 == 0;
      cca = !(e.hb || e.vb) && mh % 8 == 1;
      q.push_back(e);
      cur = q.pop_front();
      mh = mh == 492 ? 0 : mh + 1;
      if (mh == 0) mv = mv == 311 ? 0 : mv + 1;
    end
    blank = cur.hb | cur.vb;
    chk("video", {bus.hsync, bus.vsync, bus.hblank, bus.vblank, bus.de, bus.r, bus.g, bus.b},
        {cur.hs, cur.vs, cur.hb, cur.vb, !blank, blank ? 3'b000 : rgb_of(cur.pix, colours)});
    if (cva) chk("vram_addr", 32'(bus.vram_addr), 32'(a));
    if (cca) chk("crom_addr", 32'(bus.crom_addr), 32'(ca));
  endtask
  task automatic tick(input int n, input int p);
    repeat (n) begin
      cyc(1'b1, 1'b1);
      t++;
      repeat (p - 1) cyc(1'b0, 1'b1);
    end
  endtask
  task automatic advance(input int target);
    while (t < target) tick(1, 2);
  endtask
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(i[0], 1'b0);
    t = 0;
  endtask
  task automatic measure_h(input string tag);
    int fall = -1, rise = -1, fall2 = -1, de_cnt = 0;
    logic prev = 1'b1;
    for (int k = 0; k < 900; k++) begin
      tick(1, 6);
      if (t <= 493 && bus.de) de_cnt++;
      if (prev && !bus.hsync) begin
        if (fall < 0) fall = t;
        else if (fall2 < 0) fall2 = t;
      end
      if (!prev && bus.hsync && rise < 0) rise = t;
      prev = bus.hsync;
    end
    chk({tag, " hsync fall"}, fall, 403);
    chk({tag, " hsync rise"}, rise, 443);
    chk({tag, " hsync period"}, fall2, 896);
    chk({tag, " de count"}, de_cnt, 384);
  endtask
  initial begin
    vecs[0] = '{2'b01, 8'h41, 8'h81, 11'h209, 24'b111_000_000_000_000_000_000_111};
    vecs[1] = '{2'b00, 8'h41, 8'h81, 11'h209, 24'b111_001_001_001_001_001_001_111};
    vecs[2] = '{2'b10, 8'h7F, 8'hF0, 11'h3F9, 24'b010_010_010_010_000_000_000_000};
    vecs[3] = '{2'b11, 8'h00, 8'h55, 11'h001, 24'b000_110_000_110_000_110_000_110};
    vecs[4] = '{2'b00, 8'hFF, 8'h00, 11'h7F9, 24'b001_001_001_001_001_001_001_001};
    for (int i = 0; i < 2048; i++) begin
      crom[i] = 8'((i * 73) ^ (i >> 2));
      if (i < 1024) vram[i] = 8'(i * 7 + 3);
    end
    do_reset(10);
    chk("reset outputs", {bus.hsync, bus.vsync, bus.hblank, bus.vblank, bus.de, bus.r, bus.g, bus.b}, 8'b1111_0000);
    chk("reset vram_addr", 32'(bus.vram_addr), 0);
    chk("reset crom_addr", 32'(bus.crom_addr), 0);
    measure_h("cold");
    for (int i = 0; i < 5; i++) begin
      colours = vecs[i].col;
      vram[0] = vecs[i].ch;
      crom[{vecs[i].ch, 3'd1}] = vecs[i].gl;
      do_reset(3);
      advance(988);
      chk("glyph crom_addr", 32'(bus.crom_addr), 32'(vecs[i].ca));
      for (int p = 0; p < 8; p++) begin
        tick(1, 2);
        chk("glyph rgb", {bus.r, bus.g, bus.b}, vecs[i].rgb[23 - 3 * p -: 3]);
      end
      advance(1409);
      chk("hblank outputs", {bus.hsync, bus.vsync, bus.hblank, bus.vblank, bus.de, bus.r, bus.g, bus.b}, 8'b0110_0000);
    end
    colours = 2'b10;
    do_reset(4);
    for (int c = 0; c < 48; c++) begin
      advance(8 * c + 1);
      chk("line0 vram_addr", 32'(bus.vram_addr), c);
    end
    advance(16 * 493 + 1);
    chk("line16 vram_addr", 32'(bus.vram_addr), 64);
    advance(17 * 493 + 200);
    do_reset(3);
    measure_h("after mid-line reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
